// File: rtl/voting_machine_multi_if.sv
// Ballot-side bus for voting_machine_multi: button/control inputs and published results.
interface voting_machine_multi_if #(
   parameter int NUM_CAND = 4,
   parameter int CNT_W    = 16
);
   localparam int IDX_W = $clog2(NUM_CAND);

   logic [NUM_CAND-1:0]       i_candidate;
   logic                      i_voting_over;
   logic                      i_clear;
   logic [NUM_CAND*CNT_W-1:0] o_count;
   logic [IDX_W-1:0]          o_winner;
   logic                      o_tie;
   logic                      o_valid;
   logic                      o_busy;

   modport master (
      output i_candidate, i_voting_over, i_clear,
      input  o_count, o_winner, o_tie, o_valid, o_busy
   );

   modport slave (
      input  i_candidate, i_voting_over, i_clear,
      output o_count, o_winner, o_tie, o_valid, o_busy
   );
endinterface

// File: rtl/voting_machine_multi.sv
// Multi-candidate vote counter with post-vote lockout, count snapshot on close and
// a one-candidate-per-cycle winner/tie scan.
//
// state | meaning
// IDLE  | between sessions; optional counter clear
// VOTE  | accepting button-release votes
// HOLD  | lockout after an accepted vote
// TALLY | scanning the snapshot for winner/tie
// DONE  | results valid until voting reopens
module voting_machine_multi #(
   parameter int NUM_CAND    = 4,
   parameter int CNT_W       = 16,
   parameter int HOLD_CYCLES = 16,
   parameter int IDX_W       = $clog2(NUM_CAND)
) (
   input logic                   clk,
   input logic                   rst,
   voting_machine_multi_if.slave bus
);
   localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_CAND - 1);

   typedef enum logic [2:0] {IDLE, VOTE, HOLD, TALLY, DONE} state_t;

   state_t                             state_q, state_d;
   logic [NUM_CAND-1:0][CNT_W-1:0]     cnt_q, cnt_d;
   logic [NUM_CAND-1:0][CNT_W-1:0]     snap_q, snap_d;
   logic [NUM_CAND-1:0]                prev_q;
   logic [HOLD_W-1:0]                  hold_q, hold_d;
   logic [IDX_W-1:0]                   idx_q, idx_d;
   logic [CNT_W-1:0]                   best_q, best_d;
   logic [IDX_W-1:0]                   winner_q, winner_d;
   logic                               tie_q, tie_d;
   logic                               valid_q, valid_d;
   logic                               busy_q, busy_d;
   logic [NUM_CAND-1:0]                edge_w;
   logic [IDX_W-1:0]                   sel_w;
   logic [CNT_W-1:0]                   cur_w;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         snap_q   <= '0;
         prev_q   <= '0;
         hold_q   <= '0;
         idx_q    <= '0;
         best_q   <= '0;
         winner_q <= '0;
         tie_q    <= 1'b0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         snap_q   <= snap_d;
         prev_q   <= bus.i_candidate;
         hold_q   <= hold_d;
         idx_q    <= idx_d;
         best_q   <= best_d;
         winner_q <= winner_d;
         tie_q    <= tie_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      snap_d   = snap_q;
      hold_d   = hold_q;
      idx_d    = idx_q;
      best_d   = best_q;
      winner_d = winner_q;
      tie_d    = tie_q;
      valid_d  = valid_q;
      edge_w   = prev_q & ~bus.i_candidate;
      sel_w    = '0;
      cur_w    = snap_q[idx_q];
      // Descending scan so the lowest-index release is the one left in sel_w.
      for (int k = NUM_CAND - 1; k >= 0; k--) begin
         if (edge_w[k]) sel_w = IDX_W'(k);
      end
      unique case (state_q)
         IDLE: begin
            if (bus.i_clear) cnt_d = '0;
            state_d = VOTE;
         end
         VOTE: begin
            if (bus.i_voting_over) begin
               state_d = TALLY;
               snap_d  = cnt_q;
               idx_d   = '0;
               valid_d = 1'b0;
            end else if (|edge_w) begin
               state_d = HOLD;
               if (cnt_q[sel_w] != '1) cnt_d[sel_w] = cnt_q[sel_w] + 1'b1;
            end
         end
         HOLD: begin
            if (bus.i_voting_over) begin
               state_d = TALLY;
               snap_d  = cnt_q;
               idx_d   = '0;
               valid_d = 1'b0;
               hold_d  = '0;
            end else if (hold_q == HOLD_LAST) begin
               state_d = VOTE;
               hold_d  = '0;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         TALLY: begin
            if (idx_q == '0) begin
               best_d   = cur_w;
               winner_d = '0;
               tie_d    = 1'b0;
            end else if (cur_w > best_q) begin
               best_d   = cur_w;
               winner_d = idx_q;
               tie_d    = 1'b0;
            end else if (cur_w == best_q) begin
               tie_d = 1'b1;
            end
            if (idx_q == IDX_LAST) begin
               state_d = DONE;
               valid_d = 1'b1;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            if (bus.i_clear) cnt_d = '0;
            if (!bus.i_voting_over) begin
               state_d = IDLE;
               valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == HOLD) || (state_d == TALLY);
   end

   assign bus.o_count  = snap_q;
   assign bus.o_winner = winner_q;
   assign bus.o_tie    = tie_q;
   assign bus.o_valid  = valid_q;
   assign bus.o_busy   = busy_q;
endmodule

// File: tb/tb_voting_machine_multi.sv
// Randomised and directed bench for voting_machine_multi against a cycle-counting ballot model.
module tb_voting_machine_multi;
   localparam int HOLD = 16;
   localparam int MAXC = 65535;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   voting_machine_multi_if #(.NUM_CAND(4), .CNT_W(16)) if1 ();
   voting_machine_multi_if #(.NUM_CAND(4), .CNT_W(2))  if2 ();

   voting_machine_multi #(.NUM_CAND(4), .CNT_W(16), .HOLD_CYCLES(HOLD)) dut1 (
      .clk(clk), .rst(rst), .bus(if1.slave));
   voting_machine_multi #(.NUM_CAND(4), .CNT_W(2), .HOLD_CYCLES(HOLD)) dut2 (
      .clk(clk), .rst(rst), .bus(if2.slave));

   int errors = 0;
   int checks = 0;

   // Ballot model: counts per candidate, lockout expressed as the first edge index
   // at which a new release may be accepted.
   int         m_cnt [4];
   logic [3:0] m_prev;
   bit         m_open;
   longint     cyc;
   longint     m_ready;
   logic [63:0] m_snap;

   function automatic void ref_result(output int w, output bit t);
      int mx = -1;
      int n  = 0;
      w = -1;
      foreach (m_cnt[k]) if (m_cnt[k] > mx) mx = m_cnt[k];
      foreach (m_cnt[k]) begin
         if (m_cnt[k] == mx) begin
            n++;
            if (w < 0) w = k;
         end
      end
      t = (n > 1);
   endfunction

   function automatic logic [63:0] ref_counts();
      logic [63:0] v = '0;
      for (int k = 0; k < 4; k++) v[k*16 +: 16] = m_cnt[k][15:0];
      return v;
   endfunction

   task automatic model_clear();
      foreach (m_cnt[k]) m_cnt[k] = 0;
   endtask

   task automatic step(input logic [3:0] cand, input logic vo, input logic clr);
      logic [3:0] e;
      int k;
      @(negedge clk);
      if1.i_candidate   = cand;
      if1.i_voting_over = vo;
      if1.i_clear       = clr;
      e = m_prev & ~cand;
      if (m_open && !vo && cyc >= m_ready && e != 4'b0) begin
         k = 0;
         while (!e[k]) k++;
         if (m_cnt[k] < MAXC) m_cnt[k]++;
         m_ready = cyc + HOLD + 1;
      end
      m_prev = cand;
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic open_vote();
      repeat (3) step(4'b0, 1'b0, 1'b0);
      m_open  = 1'b1;
      m_ready = 0;
   endtask

   task automatic vote(input logic [3:0] cand);
      step(cand, 1'b0, 1'b0);
      step(4'b0, 1'b0, 1'b0);
      repeat (20) step(4'b0, 1'b0, 1'b0);
   endtask

   task automatic close_and_check(input string tag);
      int lat;
      int w;
      bit t;
      m_open = 1'b0;
      step(4'b0, 1'b1, 1'b0);
      lat = 1;
      while (!if1.o_valid && lat < 20) begin
         step(4'b0, 1'b1, 1'b0);
         lat++;
      end
      ref_result(w, t);
      m_snap = ref_counts();
      checks++;
      if (lat != 5) begin
         errors++;
         $display("FAIL %s latency: got %0d cycles, want 5 (valid=%0b)", tag, lat, if1.o_valid);
      end
      checks++;
      if (if1.o_count !== m_snap) begin
         errors++;
         $display("FAIL %s count: got %h, want %h", tag, if1.o_count, m_snap);
      end
      checks++;
      if (if1.o_winner !== 2'(w) || if1.o_tie !== t) begin
         errors++;
         $display("FAIL %s winner/tie: got %0d/%0b, want %0d/%0b", tag, if1.o_winner, if1.o_tie, w, t);
      end
      checks++;
      if (if1.o_busy !== 1'b0) begin
         errors++;
         $display("FAIL %s busy in done: got %0b, want 0", tag, if1.o_busy);
      end
   endtask

   task automatic reopen(input bit clr);
      step(4'b0, 1'b1, clr);
      if (clr) model_clear();
      step(4'b0, 1'b0, 1'b0);
      open_vote();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      if1.i_candidate = '0; if1.i_voting_over = 1'b0; if1.i_clear = 1'b0;
      if2.i_candidate = '0; if2.i_voting_over = 1'b0; if2.i_clear = 1'b0;
      model_clear();
      m_prev = '0; m_open = 1'b0; cyc = 0; m_ready = 0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (if1.o_count !== 64'h0 || if1.o_valid !== 1'b0 || if1.o_busy !== 1'b0 ||
          if1.o_winner !== 2'd0 || if1.o_tie !== 1'b0) begin
         errors++;
         $display("FAIL reset: got count=%h valid=%0b busy=%0b win=%0d tie=%0b, want all 0",
                  if1.o_count, if1.o_valid, if1.o_busy, if1.o_winner, if1.o_tie);
      end
      @(negedge clk);
      rst = 1'b0;
      open_vote();
   endtask

   task automatic test_counting();
      repeat (3) vote(4'b0001);
      vote(4'b0100);
      close_and_check("basic");
      checks++;
      if (if1.o_count !== 64'h0000_0001_0000_0003 || if1.o_winner !== 2'd0 || if1.o_tie !== 1'b0) begin
         errors++;
         $display("FAIL basic_const: got %h w=%0d t=%0b, want 0000000100000003 w=0 t=0",
                  if1.o_count, if1.o_winner, if1.o_tie);
      end
      reopen(1'b0);
   endtask

   task automatic test_saturation();
      int nb;
      for (int v = 0; v < 5; v++) begin
         @(negedge clk); if2.i_candidate = 4'b0001;
         @(negedge clk); if2.i_candidate = 4'b0000;
         nb = 0;
         repeat (20) begin
            @(posedge clk); #1;
            if (if2.o_busy) nb++;
         end
         if (v == 0 || v == 4) begin
            checks++;
            if (nb != HOLD) begin
               errors++;
               $display("FAIL sat_busy vote%0d: got %0d busy cycles, want %0d", v, nb, HOLD);
            end
         end
      end
      @(negedge clk); if2.i_voting_over = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      checks++;
      if (if2.o_valid !== 1'b1 || if2.o_count !== 8'h03 || if2.o_winner !== 2'd0 || if2.o_tie !== 1'b0) begin
         errors++;
         $display("FAIL sat_count: got valid=%0b count=%h w=%0d t=%0b, want 1 03 0 0",
                  if2.o_valid, if2.o_count, if2.o_winner, if2.o_tie);
      end
   endtask

   task automatic test_simultaneous();
      int nb;
      longint base;
      base = m_cnt[3];
      step(4'b1010, 1'b0, 1'b0);
      step(4'b0000, 1'b0, 1'b0);
      nb = if1.o_busy ? 1 : 0;
      for (int j = 1; j <= HOLD; j++) begin
         step((j == 4 || j == HOLD) ? 4'b1000 : 4'b0000, 1'b0, 1'b0);
         if (if1.o_busy) nb++;
      end
      checks++;
      if (nb != HOLD) begin
         errors++;
         $display("FAIL hold_len: got %0d busy cycles, want %0d", nb, HOLD);
      end
      step(4'b0000, 1'b0, 1'b0);
      checks++;
      if (if1.o_busy !== 1'b1 || m_cnt[3] != base + 1) begin
         errors++;
         $display("FAIL late_c3: got busy=%0b model_c3_delta=%0d, want busy=1 delta=1",
                  if1.o_busy, m_cnt[3] - base);
      end
      repeat (20) step(4'b0, 1'b0, 1'b0);
      close_and_check("simul");
      reopen(1'b1);
   endtask

   task automatic test_tie();
      vote(4'b0010); vote(4'b0010);
      vote(4'b0100); vote(4'b0100);
      vote(4'b0001);
      close_and_check("tie");
      checks++;
      if (if1.o_count !== 64'h0000_0002_0002_0001 || if1.o_winner !== 2'd1 || if1.o_tie !== 1'b1) begin
         errors++;
         $display("FAIL tie_const: got %h w=%0d t=%0b, want 0000000200020001 w=1 t=1",
                  if1.o_count, if1.o_winner, if1.o_tie);
      end
      reopen(1'b1);
      close_and_check("zero");
      checks++;
      if (if1.o_count !== 64'h0 || if1.o_winner !== 2'd0 || if1.o_tie !== 1'b1) begin
         errors++;
         $display("FAIL zero_const: got %h w=%0d t=%0b, want 0 w=0 t=1",
                  if1.o_count, if1.o_winner, if1.o_tie);
      end
      reopen(1'b0);
   endtask

   task automatic test_hold_abort();
      step(4'b1000, 1'b0, 1'b0);
      step(4'b0000, 1'b0, 1'b0);
      repeat (3) step(4'b0, 1'b0, 1'b0);
      checks++;
      if (if1.o_busy !== 1'b1) begin
         errors++;
         $display("FAIL abort_inhold: got busy=%0b, want 1", if1.o_busy);
      end
      close_and_check("abort");
      checks++;
      if (if1.o_count[63:48] !== 16'd1) begin
         errors++;
         $display("FAIL abort_snap: got c3=%0d, want 1", if1.o_count[63:48]);
      end
      reopen(1'b1);
   endtask

   task automatic test_random();
      logic [3:0] c;
      for (int r = 0; r < 3; r++) begin
         c = '0;
         for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) c = 4'($urandom_range(0, 15));
            step(c, 1'b0, 1'b0);
         end
         repeat (3) step(4'b0, 1'b0, 1'b0);
         close_and_check($sformatf("rand%0d", r));
         reopen(r == 1);
      end
   endtask

   task automatic test_clear_revote();
      close_and_check("pre_clear");
      step(4'b0, 1'b1, 1'b1);
      model_clear();
      checks++;
      if (if1.o_count !== m_snap || if1.o_valid !== 1'b1) begin
         errors++;
         $display("FAIL done_clear: got count=%h valid=%0b, want %h valid=1", if1.o_count, if1.o_valid, m_snap);
      end
      step(4'b0, 1'b0, 1'b0);
      step(4'b0, 1'b0, 1'b0);
      checks++;
      if (if1.o_valid !== 1'b0) begin
         errors++;
         $display("FAIL reopen_valid: got %0b, want 0", if1.o_valid);
      end
      open_vote();
      vote(4'b0100);
      close_and_check("revote");
      checks++;
      if (if1.o_count !== 64'h0000_0001_0000_0000 || if1.o_winner !== 2'd2 || if1.o_tie !== 1'b0) begin
         errors++;
         $display("FAIL revote_const: got %h w=%0d t=%0b, want 0000000100000000 w=2 t=0",
                  if1.o_count, if1.o_winner, if1.o_tie);
      end
      reopen(1'b0);
   endtask

   task automatic test_reset_in_tally();
      vote(4'b0001);
      m_open = 1'b0;
      step(4'b0, 1'b1, 1'b0);
      step(4'b0, 1'b1, 1'b0);
      step(4'b0, 1'b1, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (if1.o_valid !== 1'b0 || if1.o_count !== 64'h0 || if1.o_busy !== 1'b0 || if1.o_winner !== 2'd0) begin
         errors++;
         $display("FAIL rst_tally: got valid=%0b count=%h busy=%0b w=%0d, want 0 0 0 0",
                  if1.o_valid, if1.o_count, if1.o_busy, if1.o_winner);
      end
      model_clear();
      m_prev = '0;
      if1.i_voting_over = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      open_vote();
      vote(4'b0010);
      close_and_check("post_rst");
   endtask

   initial begin
      test_reset();
      test_counting();
      test_saturation();
      test_simultaneous();
      test_tie();
      test_hold_abort();
      test_random();
      test_clear_revote();
      test_reset_in_tally();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/voting_machine_multi.md
Name: voting_machine_multi

Overview:
Parametrised successor to the three-candidate voting machine. It counts button-release votes for NUM_CAND candidates with saturating counters and enforces a lockout hold after each accepted vote. When voting closes, it publishes a count snapshot and then runs a sequential tally that reports the winner and a tie flag. It sits between the debounced ballot buttons and the results display/readout logic.

Parameters:
NUM_CAND, 4, number of candidates (2..16)
CNT_W, 16, width of each vote counter
HOLD_CYCLES, 16, lockout cycles after an accepted vote (>=1)
IDX_W, $clog2(NUM_CAND), width of the winner index (derived; do not override)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
i_candidate  input  NUM_CAND  vote buttons; bit k = candidate k
i_voting_over  input  1  high while voting is closed
i_clear  input  1  synchronous clear of all counters; honoured only in IDLE or DONE
o_count  output  NUM_CAND*CNT_W  published counts; candidate k at bits [k*CNT_W +: CNT_W]
o_winner  output  IDX_W  index of the winning candidate
o_tie  output  1  two or more candidates share the maximum count
o_valid  output  1  o_count, o_winner and o_tie are final
o_busy  output  1  high in HOLD or TALLY

Behaviour:
- Reset (async, rst=1): state=IDLE; all counters, o_count, o_winner, o_tie and o_valid = 0; hold counter = 0; r_prev = 0.
- r_prev registers i_candidate every cycle in every state. A vote edge on bit k is r_prev[k]=1 and i_candidate[k]=0 (falling edge, i.e. button release).
- States: IDLE, VOTE, HOLD, TALLY, DONE.
- IDLE:
  - If i_clear=1, zero all counters.
  - Next state is VOTE unconditionally.
- VOTE:
  - i_voting_over=1 takes priority: go to TALLY, ignore any edges this cycle, and snapshot all counters into o_count on this edge.
  - Otherwise, if any edge is present, the lowest-index edge wins: increment that counter and go to HOLD. Other simultaneous edges are discarded.
  - The updated count is visible internally one cycle after the edge cycle.
  - Counters saturate at 2^CNT_W-1. A vote at saturation is still accepted and still enters HOLD, but the count does not change.
- HOLD:
  - i_voting_over=1 goes to TALLY with the same snapshot rule as VOTE.
  - Otherwise the hold counter increments each cycle and all edges are ignored.
  - When the hold counter reaches HOLD_CYCLES-1, clear it and return to VOTE. HOLD therefore lasts exactly HOLD_CYCLES cycles.
  - The hold counter is cleared on every exit from HOLD.
- TALLY:
  - Clear o_valid on entry.
  - Scan one candidate per cycle, idx = 0..NUM_CAND-1, over the o_count snapshot.
  - idx=0 loads best=count0, winner=0, tie=0.
  - For idx>0: count>best sets best=count, winner=idx, tie=0; count==best sets tie=1.
  - After NUM_CAND cycles go to DONE. i_voting_over is ignored during TALLY.
- DONE:
  - o_valid=1; o_winner and o_tie hold their values.
  - i_clear=1 zeros the internal counters only; o_count and o_winner are unchanged.
  - i_voting_over=0 goes to IDLE and clears o_valid. o_count and o_winner keep their last values until the next snapshot.
- Winner and tie rules:
  - The winner is the lowest index among the candidates holding the maximum.
  - All-zero counts give winner=0, tie=1 (for NUM_CAND>=2).
- o_busy = (state==HOLD) or (state==TALLY), registered with the state.
- Reset asserted mid-HOLD or mid-TALLY aborts immediately to reset values. No partial results are kept.

Test Plan:
1. Reset, then press/release c0 three times and c2 once (each release followed by at least 20 idle cycles), then assert i_voting_over → o_count = {0,1,0,3} (c3..c0); o_valid rises 5 cycles after the close (1 transition cycle + 4 scan cycles); o_winner=0, o_tie=0.
2. Release c1 and c3 in the same cycle → only count1 increments; o_busy is high for exactly 16 cycles; a c3 release during the hold is ignored, and a c3 release 1 cycle after the hold ends is counted.
3. c1=2, c2=2, c0=1 votes, then close → o_winner=1, o_tie=1; with no votes at all → o_winner=0, o_tie=1.
4. CNT_W=2: five c0 votes → count0 = 3 (saturated); the fifth vote still produces a 16-cycle o_busy pulse.
5. Assert i_voting_over 3 cycles into HOLD → hold aborts, TALLY runs; the snapshot includes the vote that caused the hold.
6. In DONE, pulse i_clear, drop i_voting_over, add one c2 vote, close again → o_count = {0,1,0,0}, o_winner=2, o_tie=0. Separately, assert rst during TALLY → o_valid=0 and all counts are 0 on the same cycle.
